// File: rtl/axis_uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : axis_uart_pkg
// Purpose : Shared types and width helpers for the AXI-Stream UART TX arbiter.
//           Holds the arbiter FSM state enum and the port-index / beat-counter
//           width constants and the function that derives them.
// Revision: 1.0  initial release
// ============================================================================
package axis_uart_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // $clog2 clamped to at least one bit so a counter or index never has zero width
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_NUM_PORTS  = 4;
   localparam int DEF_MAX_BURST  = 16;
   localparam int DEF_PORT_IDX_W = clog2_min1(DEF_NUM_PORTS);
   localparam int DEF_BEAT_CNT_W = clog2_min1(DEF_MAX_BURST);

endpackage
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_encoder
// Purpose : Combinational round-robin selector. Searches the request vector
//           upward starting one past the last granted index, wrapping.
// Ports   : req_i      - request vector, one bit per port
//           last_idx_i - index granted last time
//           gnt_o      - one-hot winner (zero when no request)
//           idx_o      - binary index of the winner
//           any_o      - at least one request is present
// Revision: 1.0  initial release
// ============================================================================
module rr_priority_encoder
   import axis_uart_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int IDX_W     = clog2_min1(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [IDX_W-1:0]     last_idx_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [IDX_W-1:0]     idx_o,
   output logic                 any_o
);

   always_comb begin
      logic             found;
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      gnt_o = '0;
      idx_o = '0;
      any_o = |req_i;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      // Offsets 1..NUM_PORTS visit every port once, the last grantee last
      for (int i = 1; i <= NUM_PORTS; i++) begin
         sum = {1'b0, last_idx_i} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_PORTS)) begin
            sum = sum - (IDX_W+1)'(NUM_PORTS);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axis_uart_tx_arbiter
// Purpose : Round-robin arbiter merging NUM_PORTS AXI-Stream byte sources onto
//           one UART TX stream. A grant lasts until a beat with tlast, where
//           tlast is the source's tlast or the MAX_BURST-th beat of the grant.
// Ports   : clk_i, arstn_i          - clock, async active-low reset
//           s_axis_*                - requester side, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//           m_axis_*                - stream to the UART transmitter
//           grant_o                 - one-hot current grant, zero when idle
//           busy_o                  - a grant is held
// Revision: 1.0  initial release
// ============================================================================
module axis_uart_tx_arbiter
   import axis_uart_pkg::*;
#(
   parameter int NUM_PORTS  = DEF_NUM_PORTS,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = DEF_MAX_BURST
) (
   input  logic                            clk_i,
   input  logic                            arstn_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata_i,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid_i,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast_i,
   output logic [NUM_PORTS-1:0]            s_axis_tready_o,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata_o,
   output logic                            m_axis_tvalid_o,
   output logic                            m_axis_tlast_o,
   input  logic                            m_axis_tready_i,
   output logic [NUM_PORTS-1:0]            grant_o,
   output logic                            busy_o
);

   localparam int IDX_W = clog2_min1(NUM_PORTS);
   localparam int CNT_W = clog2_min1(MAX_BURST);

   // Reset asserts asynchronously but releases two clocks later, in step with clk_i
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   arb_state_t           state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [NUM_PORTS-1:0] rr_gnt;
   logic [IDX_W-1:0]     rr_idx;
   logic                 rr_any;
   logic                 busy;
   logic                 hs;

   rr_priority_encoder #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr (
      .req_i      (s_axis_tvalid_i),
      .last_idx_i (last_q),
      .gnt_o      (rr_gnt),
      .idx_o      (rr_idx),
      .any_o      (rr_any)
   );

   assign busy = (state_q == ST_GRANT);

   // Pass-through datapath: no buffering, the granted port drives m_axis directly
   always_comb begin
      m_axis_tdata_o  = '0;
      m_axis_tvalid_o = 1'b0;
      m_axis_tlast_o  = 1'b0;
      if (busy) begin
         m_axis_tdata_o  = s_axis_tdata_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tvalid_o = s_axis_tvalid_i[idx_q];
         m_axis_tlast_o  = s_axis_tlast_i[idx_q] | (cnt_q == CNT_W'(MAX_BURST-1));
      end
   end

   assign s_axis_tready_o = grant_q & {NUM_PORTS{m_axis_tready_i}};
   assign hs              = m_axis_tvalid_o & m_axis_tready_i;
   assign grant_o         = grant_q;
   assign busy_o          = busy;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rr_any) begin
               state_d = ST_GRANT;
               grant_d = rr_gnt;
               idx_d   = rr_idx;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (hs) begin
               if (m_axis_tlast_o) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  last_d  = idx_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         last_q  <= IDX_W'(NUM_PORTS-1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_uart_tx_arbiter
// Purpose : Self-checking bench for axis_uart_tx_arbiter (4 ports, 8-bit data,
//           MAX_BURST=4). Sources are per-port byte FIFOs; a transaction-level
//           model of the arbitration rules predicts every output each cycle.
// Revision: 1.0  initial release
// ============================================================================
module tb_axis_uart_tx_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            arstn = 1'b0;
   logic [NP*DW-1:0] s_tdata = '0;
   logic [NP-1:0]   s_tvalid = '0;
   logic [NP-1:0]   s_tlast = '0;
   logic [NP-1:0]   s_tready;
   logic [DW-1:0]   m_tdata;
   logic            m_tvalid;
   logic            m_tlast;
   logic            m_tready = 1'b0;
   logic [NP-1:0]   grant;
   logic            busy;

   always #5 clk = ~clk;

   axis_uart_tx_arbiter #(
      .NUM_PORTS  (NP),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk_i           (clk),
      .arstn_i         (arstn),
      .s_axis_tdata_i  (s_tdata),
      .s_axis_tvalid_i (s_tvalid),
      .s_axis_tlast_i  (s_tlast),
      .s_axis_tready_o (s_tready),
      .m_axis_tdata_o  (m_tdata),
      .m_axis_tvalid_o (m_tvalid),
      .m_axis_tlast_o  (m_tlast),
      .m_axis_tready_i (m_tready),
      .grant_o         (grant),
      .busy_o          (busy)
   );

   // ---------------- source FIFOs ----------------
   logic [7:0] q_data [NP][256];
   logic       q_last [NP][256];
   int         q_head [NP];
   int         q_cnt  [NP];
   logic [NP-1:0] bubble = '0;
   bit         rnd_mode = 1'b0;

   // ---------------- reference model ----------------
   bit         md_busy;
   int         md_port, md_beats, md_lastg;
   int         log_n;
   int         log_port [8192];
   logic [7:0] log_data [8192];
   bit         log_last [8192];
   int         log_cyc  [8192];
   int         cyc;
   int         total_beats, total_pushed;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_b35 [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
   int         exp_p35 [6] = '{0, 0, 0, 2, 2, 2};
   bit         exp_l35 [6] = '{0, 0, 1, 0, 0, 1};
   int         exp_p36 [5] = '{0, 1, 2, 3, 0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      md_busy  = 1'b0;
      md_port  = 0;
      md_beats = 0;
      md_lastg = NP - 1;
   endtask

   task automatic clear_sources();
      for (int k = 0; k < NP; k++) begin
         q_head[k] = 0;
         q_cnt[k]  = 0;
      end
      bubble = '0;
   endtask

   task automatic drive();
      for (int k = 0; k < NP; k++) begin
         if (q_cnt[k] > 0) begin
            s_tvalid[k]          = !bubble[k];
            s_tlast[k]           = q_last[k][q_head[k]];
            s_tdata[k*DW +: DW]  = q_data[k][q_head[k]];
         end else begin
            s_tvalid[k]          = 1'b0;
            s_tlast[k]           = 1'b0;
            s_tdata[k*DW +: DW]  = '0;
         end
      end
   endtask

   task automatic push(input int p, input logic [7:0] first, input int len, input bit with_last);
      for (int i = 0; i < len; i++) begin
         int slot;
         slot = (q_head[p] + q_cnt[p]) % 256;
         q_data[p][slot] = first + 8'(i);
         q_last[p][slot] = with_last && (i == len - 1);
         q_cnt[p]++;
      end
   endtask

   // Advance the model by one rising edge using the values driven during the cycle
   task automatic model_clock();
      cyc++;
      if (!arstn) begin
         model_reset();
         return;
      end
      if (md_busy) begin
         if (s_tvalid[md_port] && m_tready) begin
            bit end_burst;
            end_burst = s_tlast[md_port] || (md_beats == MB - 1);
            if (log_n < 8192) begin
               log_port[log_n] = md_port;
               log_data[log_n] = s_tdata[md_port*DW +: DW];
               log_last[log_n] = end_burst;
               log_cyc[log_n]  = cyc;
            end
            log_n++;
            total_beats++;
            q_head[md_port] = (q_head[md_port] + 1) % 256;
            q_cnt[md_port]--;
            if (end_burst) begin
               md_busy  = 1'b0;
               md_lastg = md_port;
               md_beats = 0;
            end else begin
               md_beats++;
            end
         end
      end else if (s_tvalid != '0) begin
         bit found;
         found = 1'b0;
         for (int i = 1; i <= NP; i++) begin
            int p;
            p = (md_lastg + i) % NP;
            if (!found && s_tvalid[p]) begin
               found    = 1'b1;
               md_busy  = 1'b1;
               md_port  = p;
               md_beats = 0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      if (rnd_mode) begin
         for (int k = 0; k < NP; k++) bubble[k] = ($urandom_range(0, 4) == 0);
         m_tready = ($urandom_range(0, 3) != 0);
      end
      drive();
   endtask

   task automatic wait_beats(input int n, input int budget, input string name);
      int b;
      b = 0;
      while (log_n < n && b < budget) begin
         step();
         b++;
      end
      vectors++;
      if (log_n < n) begin
         miscompares++;
         $display("FAIL %s timeout: got %0d beats expected %0d", name, log_n, n);
      end
   endtask

   task automatic do_reset();
      arstn = 1'b0;
      model_reset();
      clear_sources();
      drive();
      repeat (3) step();
      arstn = 1'b1;
      repeat (4) step();
      log_n = 0;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [NP-1:0] e_grant, e_ready;
      logic          e_valid, e_last;
      e_grant = md_busy ? NP'(1 << md_port) : '0;
      e_ready = (md_busy && m_tready) ? NP'(1 << md_port) : '0;
      e_valid = md_busy && s_tvalid[md_port];
      e_last  = md_busy && (s_tlast[md_port] || (md_beats == MB - 1));
      check("grant_o", grant, e_grant);
      check("busy_o", busy, md_busy);
      check("m_tvalid", m_tvalid, e_valid);
      check("m_tlast", m_tlast, e_last);
      check("s_tready", s_tready, e_ready);
      if (e_valid) check("m_tdata", m_tdata, s_tdata[md_port*DW +: DW]);
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      clear_sources();
      cyc = 0;
      log_n = 0;
      total_beats = 0;
      total_pushed = 0;
      drive();

      // Reset, all idle
      do_reset();
      repeat (20) begin
         step();
         check("idle_grant", grant, 0);
         check("idle_tvalid", m_tvalid, 0);
      end

      // Two simultaneous 3-byte packets on ports 0 and 2
      do_reset();
      m_tready = 1'b1;
      push(0, 8'h10, 3, 1'b1);
      push(2, 8'h20, 3, 1'b1);
      drive();
      wait_beats(6, 40, "two_pkts");
      for (int i = 0; i < 6; i++) begin
         check("pkt_data", log_data[i], exp_b35[i]);
         check("pkt_port", log_port[i], exp_p35[i]);
         check("pkt_last", log_last[i], exp_l35[i]);
      end

      // All ports with 1-byte packets: rotation 0,1,2,3,0 with one idle cycle
      do_reset();
      m_tready = 1'b1;
      for (int k = 0; k < NP; k++) begin
         push(k, 8'h30 + 8'(k), 1, 1'b1);
         push(k, 8'h38 + 8'(k), 1, 1'b1);
      end
      drive();
      wait_beats(5, 40, "rotation");
      for (int i = 0; i < 5; i++) check("rr_order", log_port[i], exp_p36[i]);
      for (int i = 0; i < 4; i++) check("rr_gap", log_cyc[i+1] - log_cyc[i], 2);

      // Port 1 streams 10 bytes without tlast: released every MB beats
      do_reset();
      m_tready = 1'b1;
      push(1, 8'h40, 10, 1'b0);
      drive();
      wait_beats(10, 60, "burst_cap");
      for (int i = 0; i < 10; i++) begin
         check("cap_port", log_port[i], 1);
         check("cap_last", log_last[i], (i == 3 || i == 7));
      end
      step();
      check("held_busy", busy, 1);
      check("held_grant", grant, 4'b0010);

      // Back-pressure for 50 cycles mid-packet
      do_reset();
      m_tready = 1'b1;
      push(0, 8'hA0, 5, 1'b1);
      drive();
      wait_beats(2, 20, "stall_pre");
      m_tready = 1'b0;
      drive();
      repeat (50) begin
         step();
         check("stall_data", m_tdata, 8'hA2);
         check("stall_valid", m_tvalid, 1);
         check("stall_ready", s_tready, 0);
      end
      m_tready = 1'b1;
      drive();
      wait_beats(5, 20, "stall_post");
      check("stall_cnt", log_n, 5);
      check("stall_tail", log_data[4], 8'hA4);
      check("stall_mid", log_data[2], 8'hA2);

      // Reset pulsed mid-packet
      do_reset();
      m_tready = 1'b1;
      push(2, 8'h50, 5, 1'b1);
      drive();
      wait_beats(2, 20, "rst_pre");
      arstn = 1'b0;
      model_reset();
      clear_sources();
      drive();
      #1;
      check("rst_grant", grant, 0);
      check("rst_valid", m_tvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_last", m_tlast, 0);
      check("rst_ready", s_tready, 0);
      repeat (3) step();
      arstn = 1'b1;
      repeat (4) step();
      log_n = 0;
      push(2, 8'h60, 1, 1'b1);
      push(0, 8'h70, 1, 1'b1);
      drive();
      wait_beats(2, 20, "rst_post");
      check("rst_first", log_port[0], 0);
      check("rst_second", log_port[1], 2);

      // Randomized traffic
      do_reset();
      total_beats = 0;
      total_pushed = 0;
      rnd_mode = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         step();
         if ($urandom_range(0, 3) == 0) begin
            int p, len;
            p   = $urandom_range(0, NP - 1);
            len = $urandom_range(1, 6);
            if (q_cnt[p] + len < 200) begin
               push(p, 8'($urandom), len, ($urandom_range(0, 3) != 0));
               total_pushed += len;
            end
         end
         drive();
      end
      rnd_mode = 1'b0;
      bubble = '0;
      m_tready = 1'b1;
      drive();
      begin
         int b;
         b = 0;
         while ((q_cnt[0] + q_cnt[1] + q_cnt[2] + q_cnt[3]) > 0 && b < 3000) begin
            step();
            b++;
         end
      end
      check("rand_drained", total_beats, total_pushed);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
